// File: rtl/wr_arb_pkg.sv
// Shared constants, state encoding and legal-code predicate for the register-file write-port arbiter.
// WRARB_BCAST_SEQ_EN adds the BCAST state and its 20-step enable sequencer.
package wr_arb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned N_DEST = 20;
  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] DEST_PC   = 5'd15;
  localparam logic [CODE_W-1:0] DEST_TOTR = 5'd16;
  localparam logic [CODE_W-1:0] DEST_MDDR = 5'd17;
  localparam logic [CODE_W-1:0] DEST_TR   = 5'd18;
  localparam logic [CODE_W-1:0] DEST_AR   = 5'd21;
  localparam logic [CODE_W-1:0] DEST_IR   = 5'd22;
  localparam logic [CODE_W-1:0] DEST_ALL  = 5'd31;

`ifdef WRARB_BCAST_SEQ_EN
  localparam int unsigned       CNT_W      = 5;
  localparam logic [CNT_W-1:0]  BCAST_LAST = 5'd19;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_BCAST} state_e;
`else
  typedef enum logic {ST_IDLE, ST_WRITE} state_e;
`endif

  // R1..R14 occupy codes 1..14; the named specials follow.
  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    return code inside {[5'd1:5'd14], DEST_PC, DEST_TOTR, DEST_MDDR, DEST_TR,
                        DEST_AR, DEST_IR, DEST_ALL};
  endfunction

endpackage

// File: rtl/wr_dest_decode.sv
// Destination code to one-hot register write enable, with an illegal-code flag.
module wr_dest_decode import wr_arb_pkg::*; (
  input  logic [CODE_W-1:0] i_code,
  output logic [N_DEST-1:0] o_wen,
  output logic              o_illegal
);

  always_comb begin
    o_wen     = '0;
    o_illegal = !is_legal(i_code);
    case (i_code)
      DEST_AR:  o_wen[N_DEST-2] = 1'b1;
      DEST_IR:  o_wen[N_DEST-1] = 1'b1;
      DEST_ALL: o_wen = '1;
      default:  if (!o_illegal) o_wen = N_DEST'(1) << (i_code - 5'd1);
    endcase
  end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter for the single register-file write port; registers the winner's data and enables.
// WRARB_BCAST_SEQ_EN turns code 31 into a 20-cycle one-hot broadcast sequence instead of an all-ones write.
module wr_port_arbiter import wr_arb_pkg::*; (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [CODE_W*N_REQ-1:0] dest,
  input  logic [DATA_W*N_REQ-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_DEST-1:0]       WrEn,
  output logic [DATA_W-1:0]       WrData,
  output logic                    busy,
  output logic                    err
);

  state_e              r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_DEST-1:0]   r_wren;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic [1:0]          r_last;
`ifdef WRARB_BCAST_SEQ_EN
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;
`endif

  logic [N_REQ-1:0]    w_elig;
  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic [CODE_W-1:0]   w_win_dest;
  logic [DATA_W-1:0]   w_win_data;
  logic [N_DEST-1:0]   w_dec_wen;
  logic                w_dec_illegal;

  // The requester granted last cycle still has req high; keep it out of this round.
  assign w_elig = (r_state == ST_IDLE) ? req : (req & ~r_gnt);

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      w_idx = 2'((int'(r_last) + k + 1) % 3);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_dest = dest[CODE_W*int'(w_win) +: CODE_W];
  assign w_win_data = data[DATA_W*int'(w_win) +: DATA_W];

  wr_dest_decode u_dec (
    .i_code    (w_win_dest),
    .o_wen     (w_dec_wen),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_wren  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_last  <= 2'd2;
`ifdef WRARB_BCAST_SEQ_EN
      r_busy  <= 1'b0;
      r_cnt   <= '0;
`endif
    end
`ifdef WRARB_BCAST_SEQ_EN
    // Walk the enable bit one target per cycle; arbitration is frozen meanwhile.
    else if (r_state == ST_BCAST && r_cnt != BCAST_LAST) begin
      r_cnt  <= r_cnt + 5'd1;
      r_wren <= N_DEST'(1) << (r_cnt + 5'd1);
      r_gnt  <= '0;
    end
`endif
    else begin
`ifdef WRARB_BCAST_SEQ_EN
      r_busy <= 1'b0;
      r_cnt  <= '0;
`endif
      if (w_found) begin
        r_gnt   <= N_REQ'(1) << w_win;
        r_last  <= w_win;
        r_wdata <= w_win_data;
        if (w_dec_illegal) r_err <= 1'b1;
`ifdef WRARB_BCAST_SEQ_EN
        if (w_win_dest == DEST_ALL) begin
          r_state <= ST_BCAST;
          r_busy  <= 1'b1;
          r_wren  <= N_DEST'(1);
        end else
`endif
        begin
          r_state <= ST_WRITE;
          r_wren  <= w_dec_wen;
        end
      end else begin
        r_state <= ST_IDLE;
        r_gnt   <= '0;
        r_wren  <= '0;
      end
    end
  end

  assign gnt    = r_gnt;
  assign WrEn   = r_wren;
  assign WrData = r_wdata;
  assign err    = r_err;
`ifdef WRARB_BCAST_SEQ_EN
  assign busy   = r_busy;
`else
  assign busy   = 1'b0;
`endif

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: directed vectors, a cycle-level reference model and per-cycle comparison.
// Builds with or without WRARB_BCAST_SEQ_EN and expects the matching broadcast behaviour.
module tb_wr_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [14:0] dest;
  logic [47:0] data;
  logic [2:0]  gnt;
  logic [19:0] WrEn;
  logic [15:0] WrData;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  wr_port_arbiter dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .req     (req),
    .dest    (dest),
    .data    (data),
    .gnt     (gnt),
    .WrEn    (WrEn),
    .WrData  (WrData),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the port must show after each rising edge.
  logic [2:0]  m_gnt   = '0;
  logic [19:0] m_wren  = '0;
  logic [15:0] m_wdata = '0;
  logic        m_busy  = 1'b0;
  logic        m_err   = 1'b0;
  int          m_last  = 2;
  int          m_left  = 0;
  int          m_bit   = 0;

  always @(posedge clk) begin : model
    logic [2:0]  elig;
    logic [4:0]  code;
    logic [2:0]  g;
    logic [19:0] w;
    logic [15:0] d;
    logic        b;
    logic        e;
    int          win;
    int          idx;
    int          last;
    int          left;
    int          bitn;
    g = m_gnt; w = m_wren; d = m_wdata; b = m_busy; e = m_err;
    last = m_last; left = m_left; bitn = m_bit;
    if (!rst_n) begin
      g = '0; w = '0; d = '0; b = 1'b0; e = 1'b0; last = 2; left = 0; bitn = 0;
    end else if (left > 0) begin
      bitn = bitn + 1;
      left = left - 1;
      w = 20'd1 << bitn;
      g = '0;
      b = 1'b1;
    end else begin
      elig = req & ~m_gnt;
      win = -1;
      for (int k = 0; k < 3; k++) begin
        idx = (last + 1 + k) % 3;
        if (win < 0 && elig[idx]) win = idx;
      end
      b = 1'b0;
      if (win < 0) begin
        g = '0;
        w = '0;
      end else begin
        code = dest[5*win +: 5];
        g = 3'b001 << win;
        last = win;
        d = data[16*win +: 16];
        if (code >= 5'd1 && code <= 5'd18) w = 20'd1 << (code - 5'd1);
        else if (code == 5'd21) w = 20'h40000;
        else if (code == 5'd22) w = 20'h80000;
        else if (code == 5'd31) begin
`ifdef WRARB_BCAST_SEQ_EN
          w = 20'h00001; bitn = 0; left = 19; b = 1'b1;
`else
          w = 20'hFFFFF;
`endif
        end else begin
          w = '0;
          e = 1'b1;
        end
      end
    end
    m_gnt <= g; m_wren <= w; m_wdata <= d; m_busy <= b; m_err <= e;
    m_last <= last; m_left <= left; m_bit <= bitn;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wren", 32'(WrEn), 32'd0);
      chk("rst_wdata", 32'(WrData), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      chk("mdl_gnt", 32'(gnt), 32'(m_gnt));
      chk("mdl_wren", 32'(WrEn), 32'(m_wren));
      if (m_wren != '0) chk("mdl_wdata", 32'(WrData), 32'(m_wdata));
      chk("mdl_busy", 32'(busy), 32'(m_busy));
      chk("mdl_err", 32'(err), 32'(m_err));
    end
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic single_write(input int k, input logic [4:0] code, input logic [15:0] d,
                              input logic [2:0] eg, input logic [19:0] ew);
    dest[5*k +: 5]  = code;
    data[16*k +: 16] = d;
    req = 3'b001 << k;
    @(negedge clk);
    chk("sw_gnt", 32'(gnt), 32'(eg));
    chk("sw_wren", 32'(WrEn), 32'(ew));
    chk("sw_wdata", 32'(WrData), 32'(d));
    req = '0;
    @(negedge clk);
    chk("sw_idle_wren", 32'(WrEn), 32'd0);
  endtask

  logic [2:0]  eg_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [19:0] ew_rr [4] = '{20'h00001, 20'h00002, 20'h00004, 20'h00001};
  logic [15:0] ed_rr [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA000};

  initial begin
    rst_n = 1'b0; req = '0; dest = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_wren", 32'(WrEn), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    #2 rst_n = 1'b1;

    // First grant after reset goes through the pointer starting at 0.
    dest[9:5] = 5'd5; data[31:16] = 16'hBEEF; req = 3'b010;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_wren", 32'(WrEn), 32'h00010);
    chk("t1_wdata", 32'(WrData), 32'hBEEF);
    chk("t1_err", 32'(err), 32'd0);
    req = '0;
    @(negedge clk);
    chk("t1_drop_gnt", 32'(gnt), 32'd0);

    // All three held: strict rotation 0,1,2,0.
    do_reset();
    dest = {5'd3, 5'd2, 5'd1};
    data = {16'hA002, 16'hA001, 16'hA000};
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(eg_rr[i]));
      chk("rr_wren", 32'(WrEn), 32'(ew_rr[i]));
      chk("rr_wdata", 32'(WrData), 32'(ed_rr[i]));
    end
    req = '0;
    @(negedge clk);

    // Special and illegal destinations.
    single_write(0, 5'd22, 16'h1111, 3'b001, 20'h80000);
    single_write(0, 5'd21, 16'h2222, 3'b001, 20'h40000);
    single_write(2, 5'd18, 16'h3333, 3'b100, 20'h20000);
    single_write(1, 5'd19, 16'h4444, 3'b010, 20'h00000);
    chk("illegal_err", 32'(err), 32'd1);
    single_write(2, 5'd1, 16'h5555, 3'b100, 20'h00001);
    single_write(0, 5'd0, 16'h6666, 3'b001, 20'h00000);
    chk("err_sticky", 32'(err), 32'd1);

`ifdef WRARB_BCAST_SEQ_EN
    // Broadcast walks all 20 enables; a competing request waits until the sequence ends.
    dest[4:0] = 5'd31; data[15:0] = 16'hCAFE;
    dest[14:10] = 5'd4; data[47:32] = 16'h7777;
    req = 3'b001;
    @(negedge clk);
    chk("bc0_gnt", 32'(gnt), 32'h1);
    chk("bc0_wren", 32'(WrEn), 32'h00001);
    chk("bc0_busy", 32'(busy), 32'd1);
    req = 3'b100;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chk("bc_wren", 32'(WrEn), 32'h1 << i);
      chk("bc_gnt", 32'(gnt), 32'd0);
      chk("bc_busy", 32'(busy), 32'd1);
      chk("bc_wdata", 32'(WrData), 32'hCAFE);
    end
    @(negedge clk);
    chk("bc_after_gnt", 32'(gnt), 32'h4);
    chk("bc_after_wren", 32'(WrEn), 32'h00008);
    chk("bc_after_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk);

    // Reset at broadcast cycle 7 clears everything immediately.
    req = 3'b001;
    @(negedge clk);
    req = '0;
    repeat (7) @(negedge clk);
    chk("bc7_wren", 32'(WrEn), 32'h00080);
`else
    single_write(0, 5'd31, 16'hCAFE, 3'b001, 20'hFFFFF);
    chk("noseq_busy", 32'(busy), 32'd0);

    // Reset in the middle of a write clears it immediately.
    dest[9:5] = 5'd5; req = 3'b010;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h2);
    req = '0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wren", 32'(WrEn), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    dest = {5'd3, 5'd2, 5'd1};
    req = 3'b111;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_wren", 32'(WrEn), 32'h00001);
    req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Round-robin arbiter and sequencer for the single register-file write port. Three requesters (ALU writeback, memory-return/MDDR, control unit) present a 5-bit destination code and 16-bit data. The block grants one request at a time, registers its data and decodes the destination into the 20-bit one-hot write-enable bus that drives R1–R14, PC, TOTR, MDDR, TR, AR and IR. It sits between the execute/memory stages and the register file, replacing direct decoder drive.

## Interface
- DATA_W, 16, write data width
- N_REQ, 3, number of requesters (fixed at 3; index 0 = ALU, 1 = MEM, 2 = CTRL)
- N_DEST, 20, width of write-enable bus
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester write request, level, held until granted
- dest  in  5*N_REQ  destination code per requester (slice k = [5k+4:5k])
- data  in  DATA_W*N_REQ  write data per requester
- gnt  out  N_REQ  one-cycle grant pulse, at most one bit set
- WrEn  out  N_DEST  one-hot (or all-ones) register write enables
- WrData  out  DATA_W  write data, valid whenever WrEn != 0
- busy  out  1  high while a broadcast sequence is in progress
- err  out  1  sticky flag: an illegal destination code was granted

## Operation
- Destination map: code 1..18 -> WrEn bit 0..17; 21 -> bit 18; 22 -> bit 19; 31 -> broadcast (all targets); all other codes (0, 19, 20, 23–30) illegal.
- States: IDLE, WRITE, BCAST (BCAST only with macro, see Configuration).
- Arbitration each cycle in IDLE or WRITE: eligible = req & ~gnt (requester currently being granted is masked, so its still-high req is not re-granted). Round-robin: search starts at index (last_winner+1) mod 3. last_winner resets to 2, so requester 0 wins first.
- On a clock edge with an eligible request: register winner's dest/data, set gnt[winner], set WrEn = decode(dest), WrData = data; update last_winner; state WRITE. With no eligible request: gnt, WrEn cleared; state IDLE.
- Requester protocol: drive req with stable dest/data; on seeing gnt high, drop req (or present next request) by the following edge.
- Illegal code: grant issued, WrEn = 0 for that cycle, WrData updated, err set and held until reset.
- Broadcast without macro: WrEn = all ones for one cycle, like any other write.

## Timing
- Reset (async, Reset_n low): gnt=0, WrEn=0, WrData=0, busy=0, err=0, state IDLE, last_winner=2, bcast counter=0. Asserting reset mid-write or mid-broadcast aborts immediately; no partial enable survives.
- Latency: req sampled at edge N -> gnt and WrEn both high during cycle N+1 (one-cycle registered latency).
- Throughput: one write per cycle with back-to-back requests from different requesters; a single requester can win at most every other cycle.
- Simultaneous requests: resolved by round-robin pointer only; with all three held, grant order 0,1,2,0,...

## Configuration
- WRARB_BCAST_SEQ_EN defined: code 31 enters BCAST. Grant pulse in the first cycle; a 5-bit counter 0..19 drives WrEn = one-hot bit counter, one per cycle, 20 cycles total, same WrData throughout; busy high from first through last broadcast cycle; no arbitration during BCAST (gnt=0, requests wait). After bit 19, next edge arbitrates normally (IDLE/WRITE).
- Not defined: no BCAST state or counter; code 31 produces all-ones WrEn for one cycle; busy tied 0.

## Structure
- Package wr_arb_pkg: destination code constants (DEST_PC=15, DEST_TOTR=16, DEST_MDDR=17, DEST_TR=18, DEST_AR=21, DEST_IR=22, DEST_ALL=31), N_DEST, state enum, legal-code predicate.
- Sub-module wr_dest_decode: combinational 5-bit code -> 20-bit enable plus illegal flag; instantiated once on the registered winner's code path.

## Test plan
- Reset then req[1]=1, dest=5, data=16'hBEEF -> next cycle gnt=3'b010, WrEn=20'h00010, WrData=16'hBEEF; err=0.
- All three req held with dest 1/2/3 -> grants 0,1,2 on consecutive cycles, WrEn 20'h00001, 20'h00002, 20'h00004.
- req[0] dest=22 -> WrEn=20'h80000; dest=21 -> 20'h40000; dest=19 -> gnt pulses, WrEn=0, err=1 and stays 1.
- dest=31 without macro -> WrEn=20'hFFFFF one cycle; with WRARB_BCAST_SEQ_EN -> 20 cycles WrEn 20'h00001..20'h80000, busy high, competing req[2] granted only on cycle after last bit.
- Reset_n pulsed low at broadcast cycle 7 -> WrEn, busy, gnt 0 immediately; after release, first grant goes to requester 0.
